// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C_Driver between two requesters.
// Define I2C_ARB_TIMEOUT_EN to add a watchdog that revokes a hung grant and locks out its owner.
module i2c_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CTR_SIZE       = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m1_req,
    output logic       m0_gnt,
    output logic       m1_gnt,
    input  logic       m0_ena,
    input  logic       m0_rw,
    input  logic       m0_start_transfer,
    input  logic       m0_stop_transfer,
    input  logic       m0_r_start,
    input  logic [7:0] m0_data_wr,
    output logic [7:0] m0_data_rd,
    output logic       m0_busy,
    output logic       m0_ready,
    output logic       m0_ack_err,
    input  logic       m1_ena,
    input  logic       m1_rw,
    input  logic       m1_start_transfer,
    input  logic       m1_stop_transfer,
    input  logic       m1_r_start,
    input  logic [7:0] m1_data_wr,
    output logic [7:0] m1_data_rd,
    output logic       m1_busy,
    output logic       m1_ready,
    output logic       m1_ack_err,
    output logic       drv_ena,
    output logic       drv_rw,
    output logic       drv_start_transfer,
    output logic       drv_stop_transfer,
    output logic       drv_r_start,
    output logic [7:0] drv_data_wr,
    input  logic [7:0] drv_data_rd,
    input  logic       drv_busy,
    input  logic       drv_ready,
    input  logic       drv_ack_err,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   req0Eff, req1Eff;
    logic   revoke;
    logic   stopPulse;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [CTR_SIZE-1:0] wdCount_q, wdCount_d;
    logic                lock0_q, lock0_d, lock1_q, lock1_d;
    logic                timeout_q;

    // A grant is revoked only while its owner still holds req; a normal release wins.
    always_comb begin
        revoke = 1'b0;
        if (((state_q == GRANT0) && m0_req) || ((state_q == GRANT1) && m1_req))
            revoke = (wdCount_q == CTR_SIZE'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        wdCount_d = '0;
        if ((state_q == GRANT0 || state_q == GRANT1) && (state_d == state_q))
            wdCount_d = wdCount_q + CTR_SIZE'(1);
        lock0_d = lock0_q;
        lock1_d = lock1_q;
        if (revoke && state_q == GRANT0) lock0_d = 1'b1;
        else if (!m0_req)                lock0_d = 1'b0;
        if (revoke && state_q == GRANT1) lock1_d = 1'b1;
        else if (!m1_req)                lock1_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdCount_q <= '0;
            lock0_q   <= 1'b0;
            lock1_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wdCount_q <= wdCount_d;
            lock0_q   <= lock0_d;
            lock1_q   <= lock1_d;
            timeout_q <= revoke;
        end
    end

    assign req0Eff   = m0_req & ~lock0_q;
    assign req1Eff   = m1_req & ~lock1_q;
    assign timeout   = timeout_q;
    assign stopPulse = (state_q == DRAIN) && timeout_q;
`else
    logic unusedParams;

    assign unusedParams = TIMEOUT_CYCLES[0] ^ CTR_SIZE[0];
    assign revoke       = 1'b0;
    assign req0Eff      = m0_req;
    assign req1Eff      = m1_req;
    assign timeout      = 1'b0;
    assign stopPulse    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ptr_q names the requester preferred on a tie; it flips to the other side on every release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (req0Eff && req1Eff) state_d = ptr_q ? GRANT1 : GRANT0;
                else if (req0Eff)       state_d = GRANT0;
                else if (req1Eff)       state_d = GRANT1;
            end
            GRANT0: begin
                if (!m0_req || revoke) begin
                    state_d = DRAIN;
                    ptr_d   = 1'b1;
                end
            end
            GRANT1: begin
                if (!m1_req || revoke) begin
                    state_d = DRAIN;
                    ptr_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (!drv_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_gnt = (state_q == GRANT0);
    assign m1_gnt = (state_q == GRANT1);

    always_comb begin
        drv_ena            = 1'b0;
        drv_rw             = 1'b0;
        drv_start_transfer = 1'b0;
        drv_stop_transfer  = 1'b0;
        drv_r_start        = 1'b0;
        drv_data_wr        = 8'h00;
        m0_data_rd         = 8'h00;
        m0_busy            = 1'b1;
        m0_ready           = 1'b0;
        m0_ack_err         = 1'b0;
        m1_data_rd         = 8'h00;
        m1_busy            = 1'b1;
        m1_ready           = 1'b0;
        m1_ack_err         = 1'b0;
        case (state_q)
            GRANT0: begin
                drv_ena            = m0_ena;
                drv_rw             = m0_rw;
                drv_start_transfer = m0_start_transfer;
                drv_stop_transfer  = m0_stop_transfer;
                drv_r_start        = m0_r_start;
                drv_data_wr        = m0_data_wr;
                m0_data_rd         = drv_data_rd;
                m0_busy            = drv_busy;
                m0_ready           = drv_ready;
                m0_ack_err         = drv_ack_err;
            end
            GRANT1: begin
                drv_ena            = m1_ena;
                drv_rw             = m1_rw;
                drv_start_transfer = m1_start_transfer;
                drv_stop_transfer  = m1_stop_transfer;
                drv_r_start        = m1_r_start;
                drv_data_wr        = m1_data_wr;
                m1_data_rd         = drv_data_rd;
                m1_busy            = drv_busy;
                m1_ready           = drv_ready;
                m1_ack_err         = drv_ack_err;
            end
            default: ;
        endcase
        drv_stop_transfer = drv_stop_transfer | stopPulse;
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: vector table through a scoreboard queue,
// then hand-written sequences for long drains and the optional watchdog.
module tb_i2c_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req, m1_req, m0_gnt, m1_gnt;
    logic       m0_ena, m0_rw, m0_start_transfer, m0_stop_transfer, m0_r_start;
    logic       m1_ena, m1_rw, m1_start_transfer, m1_stop_transfer, m1_r_start;
    logic [7:0] m0_data_wr, m1_data_wr, m0_data_rd, m1_data_rd;
    logic       m0_busy, m0_ready, m0_ack_err, m1_busy, m1_ready, m1_ack_err;
    logic       drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start;
    logic [7:0] drv_data_wr, drv_data_rd;
    logic       drv_busy, drv_ready, drv_ack_err;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, r0, r1, busy, e0, e1;
        logic       g0, g1, dEna;
        logic [7:0] dWr;
        logic       b0, b1;
        logic [7:0] rd1;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(16), .CTR_SIZE(5)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_ena(m0_ena), .m0_rw(m0_rw), .m0_start_transfer(m0_start_transfer),
        .m0_stop_transfer(m0_stop_transfer), .m0_r_start(m0_r_start),
        .m0_data_wr(m0_data_wr), .m0_data_rd(m0_data_rd),
        .m0_busy(m0_busy), .m0_ready(m0_ready), .m0_ack_err(m0_ack_err),
        .m1_ena(m1_ena), .m1_rw(m1_rw), .m1_start_transfer(m1_start_transfer),
        .m1_stop_transfer(m1_stop_transfer), .m1_r_start(m1_r_start),
        .m1_data_wr(m1_data_wr), .m1_data_rd(m1_data_rd),
        .m1_busy(m1_busy), .m1_ready(m1_ready), .m1_ack_err(m1_ack_err),
        .drv_ena(drv_ena), .drv_rw(drv_rw), .drv_start_transfer(drv_start_transfer),
        .drv_stop_transfer(drv_stop_transfer), .drv_r_start(drv_r_start),
        .drv_data_wr(drv_data_wr), .drv_data_rd(drv_data_rd),
        .drv_busy(drv_busy), .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rs, r0, r1, bz, e0, e1, g0, g1, de,
                          input logic [7:0] dw, input logic b0, b1, input logic [7:0] rd1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.busy = bz; v.e0 = e0; v.e1 = e1;
        v.g0 = g0; v.g1 = g1; v.dEna = de; v.dWr = dw; v.b0 = b0; v.b1 = b1; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        m0_req   = v.r0;
        m1_req   = v.r1;
        drv_busy = v.busy;
        m0_ena   = v.e0;
        m1_ena   = v.e1;
        expQ.push_back(v);
    endtask

    initial begin
        int gnt0Cycles, toCycles, stopCycles, together;
        vec_t e;

        rst = 1'b1; m0_req = 0; m1_req = 0;
        m0_ena = 0; m0_rw = 0; m0_start_transfer = 0; m0_stop_transfer = 0; m0_r_start = 0;
        m1_ena = 0; m1_rw = 0; m1_start_transfer = 0; m1_stop_transfer = 0; m1_r_start = 0;
        m0_data_wr = 8'hA5; m1_data_wr = 8'h3C;
        drv_data_rd = 8'h5A; drv_busy = 0; drv_ready = 1; drv_ack_err = 0;

        //     rst r0 r1 bz e0 e1 | g0 g1 de  dWr    b0 b1  rd1
        addVec(1, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 0, 0, 1, 0,   1, 0, 1, 8'hA5, 0, 1, 8'h00);
        addVec(0, 1, 1, 1, 1, 0,   1, 0, 1, 8'hA5, 1, 1, 8'h00);
        addVec(0, 0, 1, 0, 1, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 0, 1, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 0, 1, 0, 0, 1,   0, 1, 1, 8'h3C, 1, 0, 8'h5A);
        addVec(0, 1, 0, 1, 0, 1,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 0, 1, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 1, 0, 0, 0,   1, 0, 0, 8'hA5, 0, 1, 8'h00);
        addVec(0, 0, 1, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 1, 0, 0, 1,   0, 1, 1, 8'h3C, 1, 0, 8'h5A);
        addVec(1, 1, 1, 0, 0, 1,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 1, 0, 0, 0,   1, 0, 0, 8'hA5, 0, 1, 8'h00);
        addVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 1, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);
        addVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 8'h00, 1, 1, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            e = expQ.pop_front();
            checkOutput($sformatf("v%0d.m0_gnt", i), {7'd0, m0_gnt}, {7'd0, e.g0});
            checkOutput($sformatf("v%0d.m1_gnt", i), {7'd0, m1_gnt}, {7'd0, e.g1});
            checkOutput($sformatf("v%0d.drv_ena", i), {7'd0, drv_ena}, {7'd0, e.dEna});
            checkOutput($sformatf("v%0d.drv_data_wr", i), drv_data_wr, e.dWr);
            checkOutput($sformatf("v%0d.m0_busy", i), {7'd0, m0_busy}, {7'd0, e.b0});
            checkOutput($sformatf("v%0d.m1_busy", i), {7'd0, m1_busy}, {7'd0, e.b1});
            checkOutput($sformatf("v%0d.m1_data_rd", i), m1_data_rd, e.rd1);
            checkOutput($sformatf("v%0d.timeout", i), {7'd0, timeout}, 8'd0);
        end

        // Long drain: m1 releases while the driver is still busy with its byte.
        m0_ena = 0; m1_ena = 0;
        m1_req = 1; m0_req = 0; drv_busy = 0;
        tick();
        checkOutput("drain.m1_gnt_before", {7'd0, m1_gnt}, 8'd1);
        m1_req = 0; m0_req = 1; drv_busy = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("drain.gnt_c%0d", i), {6'd0, m0_gnt, m1_gnt}, 8'd0);
        end
        drv_busy = 0;
        tick();
        checkOutput("drain.idle_gnt0", {7'd0, m0_gnt}, 8'd0);
        tick();
        checkOutput("drain.regrant_gnt0", {7'd0, m0_gnt}, 8'd1);
        m0_req = 0;
        tick();
        tick();

        // Hold m0 request indefinitely and watch for a watchdog revoke.
        rst = 1;
        tick();
        rst = 0; m0_req = 1; m1_req = 0;
        gnt0Cycles = 0; toCycles = 0; stopCycles = 0; together = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m0_gnt) gnt0Cycles++;
            if (timeout) toCycles++;
            if (drv_stop_transfer) stopCycles++;
            if (timeout && drv_stop_transfer && !m0_gnt) together++;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        checkOutput("wd.gnt0_cycles", gnt0Cycles[7:0], 8'd16);
        checkOutput("wd.timeout_cycles", toCycles[7:0], 8'd1);
        checkOutput("wd.stop_cycles", stopCycles[7:0], 8'd1);
        checkOutput("wd.pulse_aligned", together[7:0], 8'd1);
        m1_req = 1;
        tick();
        checkOutput("wd.m1_granted", {7'd0, m1_gnt}, 8'd1);
        checkOutput("wd.m0_locked", {7'd0, m0_gnt}, 8'd0);
        m1_req = 0; m0_req = 0;
        tick();
        m0_req = 1;
        tick();
        tick();
        checkOutput("wd.m0_unlocked", {7'd0, m0_gnt}, 8'd1);
`else
        checkOutput("nowd.gnt0_cycles", gnt0Cycles[7:0], 8'd40);
        checkOutput("nowd.timeout_cycles", toCycles[7:0], 8'd0);
        checkOutput("nowd.stop_cycles", stopCycles[7:0], 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
